rob_retire: RTL and testbench
=============================

ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port dispatch_en, input, [2:0]: per-slot dispatch valid; slot 2 is oldest, non-contiguous patterns allowed.
REQ-004 SHALL have ports dispatch_T and dispatch_Told, input, [2:0][`PR-1:0]: new and previous physical register per slot.
REQ-005 SHALL have port dispatch_arch, input, [2:0][4:0]: architectural destination per slot.
REQ-006 SHALL have port fl_head, input, [`ROB-1:0]: the freelist head index before this cycle's allocations.
REQ-007 SHALL have port dispatch_idx, output, [2:0][`ROB-1:0]: ROB index assigned to each dispatched slot, combinational.
REQ-008 SHALL have ports complete_en [2:0], complete_idx [2:0][`ROB-1:0] and complete_mispredict [2:0], all inputs: completion broadcast.
REQ-009 SHALL have port retire_en, output, [2:0]: retire mask in freelist slot order, limited to 000, 100, 110 or 111.
REQ-010 SHALL have ports retire_Told and retire_T, output, [2:0][`PR-1:0]: registers freed and committed per slot.
REQ-011 SHALL have port retire_arch, output, [2:0][4:0]: architectural register committed per slot.
REQ-012 SHALL have ports recover_en (output, 1 bit) and recover_fl_head (output, [`ROB-1:0]): branch recovery request and the freelist head to restore.
REQ-013 SHALL have port rob_space, output, [5:0]: free entries, 0..32, computed from registered state only.

Function
REQ-014 SHALL be a 32-entry circular buffer with a 5-bit head and a 5-bit tail, each wrapping 31->0, and a 6-bit count.
REQ-015 SHALL allocate valid dispatch slots in order 2, 1, 0 at tail, tail+1, tail+2 (mod 32); dispatch_idx of an invalid slot SHALL be 0.
REQ-016 SHALL store per entry: T, Told, arch, complete=0, mispredict=0, and fl_snap = fl_head + (number of valid slots up to and including this slot), mod 32.
REQ-017 SHALL accept only the first rob_space valid slots; excess slots SHALL be dropped without overwriting live entries.
REQ-018 SHALL set complete, and mispredict from complete_mispredict, on the targeted entry at the clock edge; completion SHALL be visible to retire one cycle later.
REQ-019 SHALL evaluate retire combinationally from registered state: retire slot k (2, then 1, then 0) is valid iff the entry at head+(2-k) is live and complete and every older slot retires.
REQ-020 SHALL, when a retiring entry has mispredict=1, retire that entry, suppress all younger slots, assert recover_en, and drive recover_fl_head = fl_snap of that entry in the same cycle.
REQ-021 SHALL, on the cycle after recover_en, be empty: head=tail=(branch index+1) mod 32, count=0, all entries invalid; dispatch and completion in the recovery cycle SHALL be ignored.
REQ-022 SHALL update count = count + accepted dispatches - retires; space freed by retire SHALL NOT be usable by a dispatch in the same cycle.
REQ-023 SHALL ignore completion to a non-live index, and SHALL drive retire_* data to 0 for slots not retiring.

Reset
REQ-024 SHALL on reset set head=0, tail=0, count=0, and clear all valid, complete and mispredict bits.
REQ-025 SHALL during and after reset drive retire_en=0, recover_en=0, recover_fl_head=0 and rob_space=32; reset SHALL override dispatch, completion and recovery.

Structure
REQ-026 SHALL take `PR (6), `ROB (5), ROB_SIZE (32) and a rob_entry_t struct (T, Told, arch, fl_snap, complete, mispredict) from the shared package.
REQ-027 SHALL be a single module; an optional combinational sub-module rob_slot_compact SHALL be the only one, computing slot offsets and fl_snap.

Verification
REQ-028 Reset, then dispatch 111 with T=32,33,34, fl_head=0 -> dispatch_idx=0,1,2; fl_snap=1,2,3; rob_space=29 next cycle.
REQ-029 Complete idx 1 and 2 only -> retire_en=000; then complete idx 0 -> next cycle retire_en=111 with retire_Told in order 0,1,2.
REQ-030 Fill 32 entries -> rob_space=0 and a dispatch of 111 is dropped; retire 3 and dispatch 3 in the same cycle -> only retire takes effect.
REQ-031 Entry 1 completes with mispredict, entries 0-2 complete -> retire_en=110, recover_en=1, recover_fl_head=2; next cycle head=tail=2, rob_space=32.
REQ-032 Wrap: head=30, tail=30, dispatch 111 -> dispatch_idx=30,31,0; tail=1; retire after completion returns in order 30,31,0.

Source files
------------

// File: rtl/rob_retire_pkg.sv
// Shared definitions for the reorder buffer.
//   PR       : physical register index width
//   ROB      : reorder buffer index width
//   ROB_SIZE : number of reorder buffer entries
//   rob_entry_t : payload held per entry. Liveness is tracked separately.
package rob_retire_pkg;

    localparam int PR       = 6;
    localparam int ROB      = 5;
    localparam int ROB_SIZE = 32;

    typedef struct packed {
        logic [PR-1:0]  T;
        logic [PR-1:0]  Told;
        logic [4:0]     arch;
        logic [ROB-1:0] fl_snap;
        logic           complete;
        logic           mispredict;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_slot_compact.sv
// rob_slot_compact: combinational placement of up to three dispatch slots.
// Slot 2 is the oldest. Each valid slot is placed after all valid older
// slots, so non-contiguous enable patterns still fill consecutive entries.
//   dispatch_en : per-slot valid
//   tail        : first free entry
//   fl_head     : freelist head before this cycle's allocations
//   space       : free entries, from registered state
//   slot_idx    : entry index per slot (0 for an invalid slot)
//   slot_snap   : freelist head after this slot's allocation
//   slot_accept : slot is valid and fits in the free space
module rob_slot_compact
    import rob_retire_pkg::*;
(
    input  logic [2:0]          dispatch_en,
    input  logic [ROB-1:0]      tail,
    input  logic [ROB-1:0]      fl_head,
    input  logic [5:0]          space,
    output logic [2:0][ROB-1:0] slot_idx,
    output logic [2:0][ROB-1:0] slot_snap,
    output logic [2:0]          slot_accept
);

    // Number of valid slots older than each slot.
    logic [2:0][1:0] older;

    always_comb begin
        older    = '0;
        older[1] = {1'b0, dispatch_en[2]};
        older[0] = {1'b0, dispatch_en[2]} + {1'b0, dispatch_en[1]};
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        assign slot_idx[gi]    = dispatch_en[gi] ? (tail + ROB'(older[gi])) : '0;
        assign slot_snap[gi]   = fl_head + ROB'(older[gi]) + ROB'(1);
        // Youngest slots are the ones dropped when space runs short.
        assign slot_accept[gi] = dispatch_en[gi] && ({4'b0, older[gi]} < space);
    end

endmodule

// File: rtl/rob_retire.sv
// rob_retire: 32-entry reorder buffer with 3-wide dispatch, completion and
// in-order retire, plus branch mispredict recovery.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   dispatch_*            : up to three new instructions (slot 2 oldest)
//   fl_head               : freelist head before this cycle's allocations
//   dispatch_idx          : entry index given to each dispatch slot
//   complete_*            : completion broadcast (index + mispredict flag)
//   retire_en / retire_*  : retiring entries, mask 000/100/110/111
//   recover_en            : a mispredicted branch retires this cycle
//   recover_fl_head       : freelist head to restore on recovery
//   rob_space             : free entries (0..32)
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           dispatch_en,
    input  logic [2:0][PR-1:0]   dispatch_T,
    input  logic [2:0][PR-1:0]   dispatch_Told,
    input  logic [2:0][4:0]      dispatch_arch,
    input  logic [ROB-1:0]       fl_head,
    output logic [2:0][ROB-1:0]  dispatch_idx,
    input  logic [2:0]           complete_en,
    input  logic [2:0][ROB-1:0]  complete_idx,
    input  logic [2:0]           complete_mispredict,
    output logic [2:0]           retire_en,
    output logic [2:0][PR-1:0]   retire_Told,
    output logic [2:0][PR-1:0]   retire_T,
    output logic [2:0][4:0]      retire_arch,
    output logic                 recover_en,
    output logic [ROB-1:0]       recover_fl_head,
    output logic [5:0]           rob_space
);

    logic [ROB-1:0]      head_q, head_d;
    logic [ROB-1:0]      tail_q, tail_d;
    logic [5:0]          count_q, count_d;
    logic [ROB_SIZE-1:0] valid_q, valid_d;
    rob_entry_t          entry_q [ROB_SIZE];
    rob_entry_t          entry_d [ROB_SIZE];

    logic [5:0]          space_raw;
    logic [2:0][ROB-1:0] slot_idx;
    logic [2:0][ROB-1:0] slot_snap;
    logic [2:0]          slot_accept;

    assign space_raw = 6'(ROB_SIZE) - count_q;

    rob_slot_compact u_compact (
        .dispatch_en (dispatch_en),
        .tail        (tail_q),
        .fl_head     (fl_head),
        .space       (space_raw),
        .slot_idx    (slot_idx),
        .slot_snap   (slot_snap),
        .slot_accept (slot_accept)
    );

    assign dispatch_idx = slot_idx;

    // Retire candidates: slot 2 looks at head, slot 0 at head+2.
    logic [2:0][ROB-1:0] ret_idx;
    logic [2:0]          ret_ready;
    logic [2:0]          ret_misp;
    logic [2:0]          ret;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ret
        assign ret_idx[gi]   = head_q + ROB'(2 - gi);
        assign ret_ready[gi] = valid_q[ret_idx[gi]] && entry_q[ret_idx[gi]].complete;
        assign ret_misp[gi]  = entry_q[ret_idx[gi]].mispredict;
    end

    // A retiring mispredicted branch blocks every younger slot.
    assign ret[2] = ret_ready[2];
    assign ret[1] = ret[2] && !ret_misp[2] && ret_ready[1];
    assign ret[0] = ret[1] && !ret_misp[1] && ret_ready[0];

    logic           recover;
    logic [ROB-1:0] br_idx;

    assign recover = |(ret & ret_misp);

    always_comb begin
        br_idx = ret_idx[0];
        if (ret[2] && ret_misp[2]) begin
            br_idx = ret_idx[2];
        end else if (ret[1] && ret_misp[1]) begin
            br_idx = ret_idx[1];
        end
    end

    // Outputs are forced idle while reset is held so nothing leaks out
    // before the first reset edge has cleared the state.
    assign retire_en       = reset ? 3'b000 : ret;
    assign recover_en      = !reset && recover;
    assign recover_fl_head = recover_en ? entry_q[br_idx].fl_snap : '0;
    assign rob_space       = reset ? 6'(ROB_SIZE) : space_raw;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ret_data
        assign retire_T[gi]    = retire_en[gi] ? entry_q[ret_idx[gi]].T    : '0;
        assign retire_Told[gi] = retire_en[gi] ? entry_q[ret_idx[gi]].Told : '0;
        assign retire_arch[gi] = retire_en[gi] ? entry_q[ret_idx[gi]].arch : '0;
    end

    logic [1:0] num_ret;
    logic [1:0] num_acc;

    assign num_ret = 2'(ret[2]) + 2'(ret[1]) + 2'(ret[0]);
    assign num_acc = 2'(slot_accept[2]) + 2'(slot_accept[1]) + 2'(slot_accept[0]);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        entry_d = entry_q;
        if (recover) begin
            // Everything younger than the branch is squashed; dispatch and
            // completion this cycle belong to the wrong path.
            valid_d = '0;
            head_d  = br_idx + ROB'(1);
            tail_d  = br_idx + ROB'(1);
            count_d = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ret[k]) begin
                    valid_d[ret_idx[k]] = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (complete_en[k] && valid_q[complete_idx[k]]) begin
                    entry_d[complete_idx[k]].complete   = 1'b1;
                    entry_d[complete_idx[k]].mispredict = complete_mispredict[k];
                end
            end
            // Accepted slots only ever land in entries that are free in
            // registered state, so they never collide with the updates above
            // on a live entry.
            for (int k = 0; k < 3; k++) begin
                if (slot_accept[k]) begin
                    entry_d[slot_idx[k]] = '{
                        T:          dispatch_T[k],
                        Told:       dispatch_Told[k],
                        arch:       dispatch_arch[k],
                        fl_snap:    slot_snap[k],
                        complete:   1'b0,
                        mispredict: 1'b0
                    };
                    valid_d[slot_idx[k]] = 1'b1;
                end
            end
            head_d  = head_q + ROB'(num_ret);
            tail_d  = tail_q + ROB'(num_acc);
            count_d = count_q + {4'b0, num_acc} - {4'b0, num_ret};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: reset, dispatch, in-order retire, full
// buffer, mispredict recovery and index wrap-around.
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic                 clock;
    logic                 reset;
    logic [2:0]           dispatch_en;
    logic [2:0][PR-1:0]   dispatch_T;
    logic [2:0][PR-1:0]   dispatch_Told;
    logic [2:0][4:0]      dispatch_arch;
    logic [ROB-1:0]       fl_head;
    logic [2:0][ROB-1:0]  dispatch_idx;
    logic [2:0]           complete_en;
    logic [2:0][ROB-1:0]  complete_idx;
    logic [2:0]           complete_mispredict;
    logic [2:0]           retire_en;
    logic [2:0][PR-1:0]   retire_Told;
    logic [2:0][PR-1:0]   retire_T;
    logic [2:0][4:0]      retire_arch;
    logic                 recover_en;
    logic [ROB-1:0]       recover_fl_head;
    logic [5:0]           rob_space;

    int n_cmp = 0;
    int n_bad = 0;

    rob_retire dut (
        .clock               (clock),
        .reset               (reset),
        .dispatch_en         (dispatch_en),
        .dispatch_T          (dispatch_T),
        .dispatch_Told       (dispatch_Told),
        .dispatch_arch       (dispatch_arch),
        .fl_head             (fl_head),
        .dispatch_idx        (dispatch_idx),
        .complete_en         (complete_en),
        .complete_idx        (complete_idx),
        .complete_mispredict (complete_mispredict),
        .retire_en           (retire_en),
        .retire_Told         (retire_Told),
        .retire_T            (retire_T),
        .retire_arch         (retire_arch),
        .recover_en          (recover_en),
        .recover_fl_head     (recover_fl_head),
        .rob_space           (rob_space)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        dispatch_en         = 3'b000;
        dispatch_T          = '0;
        dispatch_Told       = '0;
        dispatch_arch       = '0;
        fl_head             = '0;
        complete_en         = 3'b000;
        complete_idx        = '0;
        complete_mispredict = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        @(negedge clock); #1;
        n_cmp++; if (retire_en !== 3'b000) begin n_bad++; $display("FAIL reset_retire_en: got %b want 000", retire_en); end
        n_cmp++; if (recover_en !== 1'b0) begin n_bad++; $display("FAIL reset_recover_en: got %b want 0", recover_en); end
        n_cmp++; if (recover_fl_head !== 5'd0) begin n_bad++; $display("FAIL reset_recover_fl_head: got %0d want 0", recover_fl_head); end
        n_cmp++; if (rob_space !== 6'd32) begin n_bad++; $display("FAIL reset_space: got %0d want 32", rob_space); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++; if (rob_space !== 6'd32) begin n_bad++; $display("FAIL post_reset_space: got %0d want 32", rob_space); end
        n_cmp++; if (dispatch_idx !== 15'd0) begin n_bad++; $display("FAIL post_reset_idx: got %h want 0", dispatch_idx); end
        $display("test_reset done");
    endtask

    // Fresh buffer: three dispatches land at entries 0,1,2.
    task automatic test_dispatch();
        dispatch_en   = 3'b111;
        dispatch_T    = {6'd32, 6'd33, 6'd34};
        dispatch_Told = {6'd10, 6'd11, 6'd12};
        dispatch_arch = {5'd1, 5'd2, 5'd3};
        fl_head       = 5'd0;
        #1;
        n_cmp++; if (dispatch_idx !== {5'd0, 5'd1, 5'd2}) begin n_bad++; $display("FAIL dispatch_idx: got %h want %h", dispatch_idx, {5'd0, 5'd1, 5'd2}); end
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (rob_space !== 6'd29) begin n_bad++; $display("FAIL dispatch_space: got %0d want 29", rob_space); end
        n_cmp++; if (retire_en !== 3'b000) begin n_bad++; $display("FAIL dispatch_no_retire: got %b want 000", retire_en); end
        $display("test_dispatch done");
    endtask

    // Younger entries complete first; retire waits for the head.
    task automatic test_in_order_retire();
        complete_en  = 3'b111;
        complete_idx = {5'd1, 5'd2, 5'd7};   // 7 is not live and must be ignored
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (retire_en !== 3'b000) begin n_bad++; $display("FAIL inorder_wait: got %b want 000", retire_en); end
        complete_en  = 3'b100;
        complete_idx = {5'd0, 5'd0, 5'd0};
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (retire_en !== 3'b111) begin n_bad++; $display("FAIL inorder_retire_en: got %b want 111", retire_en); end
        n_cmp++; if (retire_Told !== {6'd10, 6'd11, 6'd12}) begin n_bad++; $display("FAIL inorder_told: got %h want %h", retire_Told, {6'd10, 6'd11, 6'd12}); end
        n_cmp++; if (retire_T !== {6'd32, 6'd33, 6'd34}) begin n_bad++; $display("FAIL inorder_t: got %h want %h", retire_T, {6'd32, 6'd33, 6'd34}); end
        n_cmp++; if (retire_arch !== {5'd1, 5'd2, 5'd3}) begin n_bad++; $display("FAIL inorder_arch: got %h want %h", retire_arch, {5'd1, 5'd2, 5'd3}); end
        n_cmp++; if (recover_en !== 1'b0) begin n_bad++; $display("FAIL inorder_no_recover: got %b want 0", recover_en); end
        @(negedge clock); #1;
        n_cmp++; if (rob_space !== 6'd32) begin n_bad++; $display("FAIL inorder_space: got %0d want 32", rob_space); end
        $display("test_in_order_retire done");
    endtask

    // head=tail=3. Eleven 3-wide dispatches: the last has room for only two.
    // Entry 3+n receives T=n.
    task automatic test_full();
        for (int g = 0; g < 11; g++) begin
            dispatch_en   = 3'b111;
            dispatch_T    = {6'(3 * g), 6'(3 * g + 1), 6'(3 * g + 2)};
            dispatch_Told = '0;
            dispatch_arch = {3{5'(g)}};
            @(negedge clock);
        end
        idle();
        #1;
        n_cmp++; if (rob_space !== 6'd0) begin n_bad++; $display("FAIL full_space: got %0d want 0", rob_space); end
        dispatch_en = 3'b111;
        dispatch_T  = {6'd50, 6'd51, 6'd52};
        #1;
        n_cmp++; if (dispatch_idx[2] !== 5'd3) begin n_bad++; $display("FAIL full_tail: got %0d want 3", dispatch_idx[2]); end
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (rob_space !== 6'd0) begin n_bad++; $display("FAIL full_drop_space: got %0d want 0", rob_space); end
        complete_en  = 3'b111;
        complete_idx = {5'd3, 5'd4, 5'd5};
        @(negedge clock);
        idle();
        dispatch_en = 3'b111;
        dispatch_T  = {6'd60, 6'd61, 6'd62};
        #1;
        n_cmp++; if (retire_en !== 3'b111) begin n_bad++; $display("FAIL full_retire_en: got %b want 111", retire_en); end
        n_cmp++; if (retire_T !== {6'd0, 6'd1, 6'd2}) begin n_bad++; $display("FAIL full_retire_t: got %h want %h", retire_T, {6'd0, 6'd1, 6'd2}); end
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (rob_space !== 6'd3) begin n_bad++; $display("FAIL full_same_cycle_space: got %0d want 3", rob_space); end
        dispatch_en = 3'b100;
        #1;
        n_cmp++; if (dispatch_idx[2] !== 5'd3) begin n_bad++; $display("FAIL full_tail_after: got %0d want 3", dispatch_idx[2]); end
        dispatch_en = 3'b000;
        $display("test_full done");
    endtask

    task automatic test_mispredict();
        reset = 1'b1;
        idle();
        @(negedge clock);
        reset = 1'b0;
        dispatch_en   = 3'b111;
        dispatch_T    = {6'd20, 6'd21, 6'd22};
        dispatch_Told = {6'd1, 6'd2, 6'd3};
        fl_head       = 5'd0;
        @(negedge clock);
        idle();
        complete_en         = 3'b111;
        complete_idx        = {5'd0, 5'd1, 5'd2};
        complete_mispredict = 3'b010;
        @(negedge clock);
        idle();
        // Wrong-path traffic in the recovery cycle must be ignored.
        dispatch_en  = 3'b111;
        dispatch_T   = {6'd55, 6'd56, 6'd57};
        complete_en  = 3'b100;
        complete_idx = {5'd2, 5'd0, 5'd0};
        #1;
        n_cmp++; if (retire_en !== 3'b110) begin n_bad++; $display("FAIL misp_retire_en: got %b want 110", retire_en); end
        n_cmp++; if (recover_en !== 1'b1) begin n_bad++; $display("FAIL misp_recover_en: got %b want 1", recover_en); end
        n_cmp++; if (recover_fl_head !== 5'd2) begin n_bad++; $display("FAIL misp_fl_head: got %0d want 2", recover_fl_head); end
        n_cmp++; if (retire_T !== {6'd20, 6'd21, 6'd0}) begin n_bad++; $display("FAIL misp_retire_t: got %h want %h", retire_T, {6'd20, 6'd21, 6'd0}); end
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (rob_space !== 6'd32) begin n_bad++; $display("FAIL misp_space: got %0d want 32", rob_space); end
        n_cmp++; if (retire_en !== 3'b000) begin n_bad++; $display("FAIL misp_empty: got %b want 000", retire_en); end
        n_cmp++; if (recover_en !== 1'b0) begin n_bad++; $display("FAIL misp_recover_clear: got %b want 0", recover_en); end
        dispatch_en = 3'b100;
        dispatch_T  = {6'd40, 6'd0, 6'd0};
        #1;
        n_cmp++; if (dispatch_idx[2] !== 5'd2) begin n_bad++; $display("FAIL misp_new_tail: got %0d want 2", dispatch_idx[2]); end
        @(negedge clock);
        idle();
        complete_en  = 3'b001;
        complete_idx = {5'd0, 5'd0, 5'd2};
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (retire_en !== 3'b100) begin n_bad++; $display("FAIL misp_new_head: got %b want 100", retire_en); end
        n_cmp++; if (retire_T[2] !== 6'd40) begin n_bad++; $display("FAIL misp_new_head_t: got %0d want 40", retire_T[2]); end
        @(negedge clock);
        $display("test_mispredict done");
    endtask

    // head=tail=3. Fill entries 3..29 with a mispredict at 29 (slot 0 of the
    // last retire group) so the buffer restarts at 30, then wrap.
    task automatic test_wrap();
        bit found;
        for (int g = 0; g < 10; g++) begin
            idle();
            if (g < 9) begin
                dispatch_en = 3'b111;
                dispatch_T  = {6'(3 * g), 6'(3 * g + 1), 6'(3 * g + 2)};
                fl_head     = 5'(3 * g);
            end
            if (g >= 1) begin
                complete_en  = 3'b111;
                complete_idx = {5'(3 * g), 5'(3 * g + 1), 5'(3 * g + 2)};
                if (g == 9) complete_mispredict = 3'b001;
            end
            @(negedge clock);
        end
        idle();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (recover_en === 1'b1) begin
                found = 1'b1;
                n_cmp++; if (retire_en !== 3'b111) begin n_bad++; $display("FAIL wrap_br_retire_en: got %b want 111", retire_en); end
                n_cmp++; if (recover_fl_head !== 5'd27) begin n_bad++; $display("FAIL wrap_br_fl_head: got %0d want 27", recover_fl_head); end
                n_cmp++; if (retire_T[0] !== 6'd26) begin n_bad++; $display("FAIL wrap_br_t: got %0d want 26", retire_T[0]); end
            end
            @(negedge clock);
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL wrap_br_timeout: got no recover_en want recover_en within 10 cycles"); end
        dispatch_en = 3'b111;
        dispatch_T  = {6'd1, 6'd2, 6'd3};
        #1;
        n_cmp++; if (dispatch_idx !== {5'd30, 5'd31, 5'd0}) begin n_bad++; $display("FAIL wrap_idx: got %h want %h", dispatch_idx, {5'd30, 5'd31, 5'd0}); end
        @(negedge clock);
        idle();
        complete_en  = 3'b111;
        complete_idx = {5'd30, 5'd31, 5'd0};
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (retire_en !== 3'b111) begin n_bad++; $display("FAIL wrap_retire_en: got %b want 111", retire_en); end
        n_cmp++; if (retire_T !== {6'd1, 6'd2, 6'd3}) begin n_bad++; $display("FAIL wrap_retire_t: got %h want %h", retire_T, {6'd1, 6'd2, 6'd3}); end
        @(negedge clock);
        // Non-contiguous dispatch: slots 2 and 0 take consecutive entries.
        dispatch_en = 3'b101;
        dispatch_T  = {6'd7, 6'd8, 6'd9};
        #1;
        n_cmp++; if (dispatch_idx !== {5'd1, 5'd0, 5'd2}) begin n_bad++; $display("FAIL gap_idx: got %h want %h", dispatch_idx, {5'd1, 5'd0, 5'd2}); end
        @(negedge clock);
        idle();
        complete_en  = 3'b100;
        complete_idx = {5'd2, 5'd0, 5'd0};
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (retire_en !== 3'b000) begin n_bad++; $display("FAIL gap_wait: got %b want 000", retire_en); end
        complete_en  = 3'b010;
        complete_idx = {5'd0, 5'd1, 5'd0};
        @(negedge clock);
        idle();
        #1;
        n_cmp++; if (retire_en !== 3'b110) begin n_bad++; $display("FAIL gap_retire_en: got %b want 110", retire_en); end
        n_cmp++; if (retire_T !== {6'd7, 6'd9, 6'd0}) begin n_bad++; $display("FAIL gap_retire_t: got %h want %h", retire_T, {6'd7, 6'd9, 6'd0}); end
        @(negedge clock); #1;
        n_cmp++; if (rob_space !== 6'd32) begin n_bad++; $display("FAIL gap_space: got %0d want 32", rob_space); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_in_order_retire();
        test_full();
        test_mispredict();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
